// File: rtl/ysyx_25040129_cache_pkg.sv
// Shared cache definitions: controller state encodings and AXI response/burst codes.
package ysyx_25040129_cache_pkg;

    typedef enum logic [1:0] {
        IDLE           = 2'd0,
        WAIT_IFU_READY = 2'd1,
        WAIT_OUT_READY = 2'd2,
        WAIT_OUT_REQ   = 2'd3
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

endpackage

// File: rtl/ysyx_25040129_icache_way.sv
// One cache way: per-set line data, tag and valid bit, with an asynchronous
// read port so a hit can be answered in the request cycle.
module ysyx_25040129_icache_way
    import ysyx_25040129_cache_pkg::*;
#(
    parameter int OFF_W = 2,
    parameter int IDX_W = 3,
    parameter int TAG_W = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic [IDX_W-1:0] i_rd_idx,
    input  logic [OFF_W-1:0] i_rd_off,
    input  logic [TAG_W-1:0] i_rd_tag,
    output logic             o_hit,
    output logic             o_valid,
    output logic [31:0]      o_word,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [OFF_W-1:0] i_wr_off,
    input  logic [31:0]      i_wr_data,
    input  logic [TAG_W-1:0] i_wr_tag,
    input  logic             i_fill_set,
    input  logic             i_fill_clr
);
    localparam int SETS  = 1 << IDX_W;
    localparam int WORDS = 1 << OFF_W;

    logic [31:0]      r_data [SETS][WORDS];
    logic [TAG_W-1:0] r_tag  [SETS];
    logic [SETS-1:0]  r_valid;

    // Data and tags carry no reset; only the valid bits define cache contents.
    always_ff @(posedge clk) begin
        if (i_wr_en)
            r_data[i_wr_idx][i_wr_off] <= i_wr_data;
        if (i_fill_set)
            r_tag[i_wr_idx] <= i_wr_tag;
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush)
            r_valid <= '0;
        else if (i_fill_set)
            r_valid[i_wr_idx] <= 1'b1;
        else if (i_fill_clr)
            r_valid[i_wr_idx] <= 1'b0;
    end

    assign o_valid = r_valid[i_rd_idx];
    assign o_hit   = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);
    assign o_word  = r_data[i_rd_idx][i_rd_off];

endmodule

// File: rtl/ysyx_25040129_icache_assoc.sv
// Set-associative instruction cache: same-cycle hits, AXI INCR burst line refill,
// per-set round-robin replacement and fence.i invalidate-all.
module ysyx_25040129_icache_assoc
    import ysyx_25040129_cache_pkg::*;
#(
    parameter int BLOCK_SIZE_WORD_DIG = 2,
    parameter int SET_NUM_DIG         = 3,
    parameter int WAY_NUM_DIG         = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ifu_araddr,
    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,
    output logic [31:0] out_araddr,
    output logic        out_arvalid,
    input  logic        out_arready,
    output logic [7:0]  out_arlen,
    output logic [1:0]  out_arburst,
    input  logic [31:0] out_rdata,
    input  logic [1:0]  out_rresp,
    input  logic        out_rvalid,
    output logic        out_rready,
    input  logic        out_rlast,
    input  logic        fence_i
);
    localparam int BSD   = BLOCK_SIZE_WORD_DIG + 2;
    localparam int OFF_W = BLOCK_SIZE_WORD_DIG;
    localparam int TAG_W = 32 - BSD - SET_NUM_DIG;
    localparam int SETS  = 1 << SET_NUM_DIG;
    localparam int WAYS  = 1 << WAY_NUM_DIG;
    localparam int WAY_W = (WAY_NUM_DIG == 0) ? 1 : WAY_NUM_DIG;

    state_t                 r_state;
    logic [31:2]            r_addr;
    logic [WAY_W-1:0]       r_victim;
    logic [OFF_W-1:0]       r_beat_cnt;
    logic                   r_err;
    logic [1:0]             r_resp;
    logic [31:0]            r_rdata;
    logic                   r_flush_pending;
    logic [WAY_W-1:0]       r_ptr [SETS];

    logic [SET_NUM_DIG-1:0] w_in_idx, w_lt_idx;
    logic [OFF_W-1:0]       w_in_off, w_lt_off;
    logic [TAG_W-1:0]       w_in_tag, w_lt_tag;
    logic [WAYS-1:0]        w_hit_vec, w_valid_vec;
    logic [WAYS-1:0][31:0]  w_word_vec;
    logic [31:0]            w_hit_word;
    logic                   w_hit, w_req, w_flush_now, w_beat, w_beat_err;
    logic                   w_fill_done, w_fill_ok, w_found;
    logic [WAY_W-1:0]       w_victim_sel;
    logic                   w_unused;

    assign w_in_idx = ifu_araddr[BSD+SET_NUM_DIG-1:BSD];
    assign w_in_off = ifu_araddr[BSD-1:2];
    assign w_in_tag = ifu_araddr[31:BSD+SET_NUM_DIG];
    assign w_lt_idx = r_addr[BSD+SET_NUM_DIG-1:BSD];
    assign w_lt_off = r_addr[BSD-1:2];
    assign w_lt_tag = r_addr[31:BSD+SET_NUM_DIG];
    assign w_unused = &{1'b0, ifu_araddr[1:0]};

    assign w_flush_now = (r_state == IDLE) && (fence_i || r_flush_pending);
    assign w_beat      = (r_state == WAIT_OUT_REQ) && out_rvalid;
    assign w_beat_err  = out_rresp != RESP_OKAY;
    assign w_fill_done = w_beat && out_rlast;
    assign w_fill_ok   = !(r_err || w_beat_err);

    genvar g;
    for (g = 0; g < WAYS; g++) begin : g_way
        ysyx_25040129_icache_way #(
            .OFF_W (OFF_W),
            .IDX_W (SET_NUM_DIG),
            .TAG_W (TAG_W)
        ) u_way (
            .clk        (clk),
            .rst        (rst),
            .i_flush    (w_flush_now),
            .i_rd_idx   (w_in_idx),
            .i_rd_off   (w_in_off),
            .i_rd_tag   (w_in_tag),
            .o_hit      (w_hit_vec[g]),
            .o_valid    (w_valid_vec[g]),
            .o_word     (w_word_vec[g]),
            .i_wr_en    (w_beat && (r_victim == WAY_W'(g))),
            .i_wr_idx   (w_lt_idx),
            .i_wr_off   (r_beat_cnt),
            .i_wr_data  (out_rdata),
            .i_wr_tag   (w_lt_tag),
            .i_fill_set (w_fill_done && w_fill_ok && (r_victim == WAY_W'(g))),
            .i_fill_clr (w_fill_done && !w_fill_ok && (r_victim == WAY_W'(g)))
        );
    end

    assign w_hit = |w_hit_vec;

    always_comb begin
        w_hit_word = '0;
        for (int i = 0; i < WAYS; i++)
            if (w_hit_vec[i]) w_hit_word = w_hit_word | w_word_vec[i];
    end

    // Fill an empty way first; only fall back to round-robin when the set is full.
    always_comb begin
        w_victim_sel = r_ptr[w_in_idx];
        w_found      = 1'b0;
        for (int i = 0; i < WAYS; i++) begin
            if (!w_valid_vec[i] && !w_found) begin
                w_victim_sel = WAY_W'(i);
                w_found      = 1'b1;
            end
        end
    end

    assign ifu_arready = (r_state == IDLE) && !fence_i && !r_flush_pending;
    assign w_req       = ifu_arready && ifu_arvalid;
    assign ifu_rvalid  = (w_req && w_hit) || (r_state == WAIT_IFU_READY);
    assign ifu_rdata   = (r_state == IDLE) ? w_hit_word : r_rdata;
    assign ifu_rresp   = (r_state == IDLE) ? RESP_OKAY : r_resp;

    assign out_arvalid = r_state == WAIT_OUT_READY;
    assign out_araddr  = {r_addr[31:BSD], {BSD{1'b0}}};
    assign out_arlen   = 8'((1 << BLOCK_SIZE_WORD_DIG) - 1);
    assign out_arburst = BURST_INCR;
    assign out_rready  = r_state == WAIT_OUT_REQ;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_flush_pending <= 1'b0;
            r_err           <= 1'b0;
            r_resp          <= RESP_OKAY;
            r_beat_cnt      <= '0;
            for (int s = 0; s < SETS; s++) r_ptr[s] <= '0;
        end else begin
            if (fence_i && r_state != IDLE)
                r_flush_pending <= 1'b1;
            else if (w_flush_now)
                r_flush_pending <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        if (w_hit) begin
                            if (!ifu_rready) begin
                                r_rdata <= w_hit_word;
                                r_resp  <= RESP_OKAY;
                                r_state <= WAIT_IFU_READY;
                            end
                        end else begin
                            r_addr     <= ifu_araddr[31:2];
                            r_victim   <= w_victim_sel;
                            r_beat_cnt <= '0;
                            r_err      <= 1'b0;
                            r_resp     <= RESP_OKAY;
                            r_state    <= WAIT_OUT_READY;
                        end
                    end
                end
                WAIT_OUT_READY: begin
                    if (out_arready) r_state <= WAIT_OUT_REQ;
                end
                WAIT_OUT_REQ: begin
                    if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (r_beat_cnt == w_lt_off) r_rdata <= out_rdata;
                        if (w_beat_err && !r_err) begin
                            r_err  <= 1'b1;
                            r_resp <= out_rresp;
                        end
                        if (out_rlast) begin
                            if (w_fill_ok && WAYS > 1)
                                r_ptr[w_lt_idx] <= r_ptr[w_lt_idx] + 1'b1;
                            r_state <= WAIT_IFU_READY;
                        end
                    end
                end
                WAIT_IFU_READY: begin
                    if (ifu_rready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25040129_icache_assoc.sv
// Self-checking bench for the associative icache: directed vector table, corner-case
// sequences and a randomized stream checked against a set/way reference model.
module tb_ysyx_25040129_icache_assoc;
    localparam int NBEATS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ifu_araddr = '0;
    logic        ifu_arvalid = 1'b0;
    logic        ifu_arready;
    logic [31:0] ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        ifu_rvalid;
    logic        ifu_rready = 1'b0;
    logic [31:0] out_araddr;
    logic        out_arvalid;
    logic        out_arready = 1'b0;
    logic [7:0]  out_arlen;
    logic [1:0]  out_arburst;
    logic [31:0] out_rdata = '0;
    logic [1:0]  out_rresp = '0;
    logic        out_rvalid = 1'b0;
    logic        out_rready;
    logic        out_rlast = 1'b0;
    logic        fence_i = 1'b0;

    always #5 clk = ~clk;

    ysyx_25040129_icache_assoc dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .out_araddr(out_araddr), .out_arvalid(out_arvalid), .out_arready(out_arready),
        .out_arlen(out_arlen), .out_arburst(out_arburst),
        .out_rdata(out_rdata), .out_rresp(out_rresp), .out_rvalid(out_rvalid),
        .out_rready(out_rready), .out_rlast(out_rlast), .fence_i(fence_i)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: 8 sets x 2 ways of {valid, tag}, one replacement pointer per set.
    bit          m_valid [8][2];
    logic [24:0] m_tag   [8][2];
    int          m_ptr   [8];

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return ({a[31:2], 2'b00} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit model_hit(logic [31:0] a);
        int s = int'(a[6:4]);
        for (int w = 0; w < 2; w++)
            if (m_valid[s][w] && m_tag[s][w] == a[31:7]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_fill(logic [31:0] a, bit ok);
        int s = int'(a[6:4]);
        int v = -1;
        for (int w = 0; w < 2; w++)
            if (!m_valid[s][w] && v < 0) v = w;
        if (v < 0) v = m_ptr[s];
        if (ok) begin
            m_valid[s][v] = 1'b1;
            m_tag[s][v]   = a[31:7];
            m_ptr[s]      = (m_ptr[s] + 1) % 2;
        end else begin
            m_valid[s][v] = 1'b0;
        end
    endfunction

    function automatic void model_flush();
        for (int s = 0; s < 8; s++)
            for (int w = 0; w < 2; w++) m_valid[s][w] = 1'b0;
    endfunction

    function automatic void model_reset();
        model_flush();
        for (int s = 0; s < 8; s++) m_ptr[s] = 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    // One IFU read, acting as refill memory on a miss. All tasks start at posedge+1.
    task automatic read_txn(input logic [31:0] addr, input int err_beat, input int hold,
                            input int fence_beat, output logic [31:0] data,
                            output logic [1:0] resp, output bit miss,
                            output logic [31:0] ra, output logic [7:0] rl);
        int cyc;
        data = '0; resp = '0; miss = 1'b0; ra = '0; rl = '0;
        ifu_araddr = addr; ifu_arvalid = 1'b1; ifu_rready = (hold == 0);
        @(negedge clk);
        cyc = 0;
        while (!ifu_arready && cyc < 20) begin @(negedge clk); cyc++; end
        if (!ifu_arready) begin
            timeout("arready"); ifu_arvalid = 1'b0; @(posedge clk); #1; return;
        end
        if (ifu_rvalid) begin
            data = ifu_rdata; resp = ifu_rresp;
            @(posedge clk); #1;
            ifu_arvalid = 1'b0;
            if (hold > 0) begin
                for (int h = 0; h < hold; h++) begin
                    @(negedge clk);
                    chk("hold rvalid", ifu_rvalid, 1);
                    chk("hold rdata", ifu_rdata, data);
                    @(posedge clk); #1;
                end
                ifu_rready = 1'b1;
                @(negedge clk);
                chk("release rvalid", ifu_rvalid, 1);
                chk("release rdata", ifu_rdata, data);
                @(posedge clk); #1;
            end
            ifu_rready = 1'b0;
            return;
        end
        miss = 1'b1;
        @(posedge clk); #1;
        ifu_arvalid = 1'b0;
        @(negedge clk);
        cyc = 0;
        while (!out_arvalid && cyc < 20) begin @(negedge clk); cyc++; end
        if (!out_arvalid) begin timeout("out_arvalid"); return; end
        ra = out_araddr; rl = out_arlen; out_arready = 1'b1;
        @(posedge clk); #1;
        out_arready = 1'b0;
        for (int b = 0; b < NBEATS; b++) begin
            out_rvalid = 1'b1;
            out_rdata  = mem_word(ra + 32'(4 * b));
            out_rresp  = (b == err_beat) ? 2'b10 : 2'b00;
            out_rlast  = (b == NBEATS - 1);
            fence_i    = (b == fence_beat);
            @(negedge clk);
            if (!out_rready) timeout("out_rready");
            @(posedge clk); #1;
        end
        out_rvalid = 1'b0; out_rlast = 1'b0; out_rresp = 2'b00; fence_i = 1'b0;
        ifu_rready = 1'b1;
        @(negedge clk);
        cyc = 0;
        while (!ifu_rvalid && cyc < 20) begin @(negedge clk); cyc++; end
        if (!ifu_rvalid) timeout("ifu_rvalid");
        data = ifu_rdata; resp = ifu_rresp;
        @(posedge clk); #1;
        ifu_rready = 1'b0;
    endtask

    task automatic do_read(input string nm, input logic [31:0] addr, input int err_beat,
                           input int hold, input int fence_beat);
        bit          exp_hit, miss;
        logic [31:0] d, ra;
        logic [1:0]  r;
        logic [7:0]  rl;
        exp_hit = model_hit(addr);
        read_txn(addr, err_beat, hold, fence_beat, d, r, miss, ra, rl);
        chk({nm, " miss"}, 32'(miss), 32'(!exp_hit));
        chk({nm, " rdata"}, d, mem_word(addr));
        if (!exp_hit) begin
            chk({nm, " araddr"}, ra, {addr[31:4], 4'h0});
            chk({nm, " arlen"}, 32'(rl), 32'd3);
            chk({nm, " rresp"}, 32'(r), (err_beat >= 0 && err_beat < NBEATS) ? 32'd2 : 32'd0);
            model_fill(addr, !(err_beat >= 0 && err_beat < NBEATS));
            if (fence_beat >= 0 && fence_beat < NBEATS) model_flush();
        end else begin
            chk({nm, " rresp"}, 32'(r), 32'd0);
        end
    endtask

    task automatic fence_pulse(input logic [31:0] addr);
        ifu_araddr = addr; ifu_arvalid = 1'b1; fence_i = 1'b1;
        @(negedge clk);
        chk("fence arready", ifu_arready, 0);
        chk("fence rvalid", ifu_rvalid, 0);
        @(posedge clk); #1;
        fence_i = 1'b0; ifu_arvalid = 1'b0;
        model_flush();
    endtask

    typedef struct {
        logic [31:0] addr;
        bit          exp_miss;
        logic [31:0] exp_araddr;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        tbl [6];
        logic [31:0] d, ra, a;
        logic [1:0]  r;
        logic [7:0]  rl;
        bit          miss;
        int          eb, fb;

        tbl[0] = '{32'h8000_0008, 1'b1, 32'h8000_0000};
        tbl[1] = '{32'h8000_000C, 1'b0, 32'h0};
        tbl[2] = '{32'h8000_0080, 1'b1, 32'h8000_0080};
        tbl[3] = '{32'h8000_0100, 1'b1, 32'h8000_0100};
        tbl[4] = '{32'h8000_0080, 1'b0, 32'h0};
        tbl[5] = '{32'h8000_0000, 1'b1, 32'h8000_0000};

        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset arready", ifu_arready, 1);
        chk("reset rvalid", ifu_rvalid, 0);
        chk("reset out_arvalid", out_arvalid, 0);
        chk("reset out_rready", out_rready, 0);
        chk("arburst", 32'(out_arburst), 32'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            read_txn(tbl[i].addr, -1, 0, -1, d, r, miss, ra, rl);
            chk($sformatf("vec%0d miss", i), 32'(miss), 32'(tbl[i].exp_miss));
            chk($sformatf("vec%0d rdata", i), d, mem_word(tbl[i].addr));
            if (tbl[i].exp_miss) begin
                chk($sformatf("vec%0d araddr", i), ra, tbl[i].exp_araddr);
                chk($sformatf("vec%0d arlen", i), 32'(rl), 32'd3);
            end
            if (!model_hit(tbl[i].addr)) model_fill(tbl[i].addr, 1'b1);
        end

        // Backpressure on a hit: 0x8000_0100 sits in way0 of set 0.
        do_read("bp", 32'h8000_0104, -1, 3, -1);

        // Flush requested mid-refill: word still delivered, one blocked IDLE cycle.
        do_read("flush fill", 32'h8000_0010, -1, 0, 1);
        @(negedge clk);
        chk("flush idle arready", ifu_arready, 0);
        @(negedge clk);
        chk("post flush arready", ifu_arready, 1);
        @(posedge clk); #1;
        do_read("flush reread", 32'h8000_0010, -1, 0, -1);

        // Refill error on beat 1, then the retry must refetch.
        do_read("err fill", 32'h8000_0024, 1, 0, -1);
        do_read("err reread", 32'h8000_0024, -1, 0, -1);

        // Reset while a refill is in progress.
        do_read("pre reset", 32'h8000_0100, -1, 0, -1);
        ifu_araddr = 32'h8000_0030; ifu_arvalid = 1'b1; ifu_rready = 1'b1;
        @(negedge clk);
        chk("rst-seq miss rvalid", ifu_rvalid, 0);
        @(posedge clk); #1;
        ifu_arvalid = 1'b0;
        @(negedge clk);
        chk("rst-seq out_arvalid", out_arvalid, 1);
        out_arready = 1'b1;
        @(posedge clk); #1;
        out_arready = 1'b0;
        out_rvalid = 1'b1; out_rdata = mem_word(32'h8000_0030);
        @(posedge clk); #1;
        out_rvalid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; ifu_rready = 1'b0;
        @(negedge clk);
        chk("mid-reset arready", ifu_arready, 1);
        chk("mid-reset out_rready", out_rready, 0);
        chk("mid-reset out_arvalid", out_arvalid, 0);
        chk("mid-reset rvalid", ifu_rvalid, 0);
        @(posedge clk); #1;
        model_reset();
        read_txn(32'h8000_0100, -1, 0, -1, d, r, miss, ra, rl);
        chk("after reset miss", 32'(miss), 32'd1);
        model_fill(32'h8000_0100, 1'b1);
        do_read("after reset 0x30", 32'h8000_0030, -1, 0, -1);

        // Randomized stream: 4 tags per set to force conflicts; low address bits vary.
        for (int i = 0; i < 60; i++) begin
            a = 32'h8000_0000 + (32'($urandom_range(0, 3)) << 7) + (32'($urandom_range(0, 7)) << 4)
              + (32'($urandom_range(0, 3)) << 2) + 32'($urandom_range(0, 3));
            eb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
            fb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
            if ($urandom_range(0, 9) == 0) fence_pulse(a);
            do_read($sformatf("rnd%0d", i), a, eb, int'($urandom_range(0, 2)), fb);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ysyx_25040129_icache_assoc.md
YSYX_25040129_ICACHE_ASSOC -- requirements
Module: ysyx_25040129_icache_assoc

Interface
REQ-001 SHALL have parameter BLOCK_SIZE_WORD_DIG, default 2: log2 of 32-bit words per line, legal range 1..3.
REQ-002 SHALL have parameter SET_NUM_DIG, default 3: log2 of the number of sets.
REQ-003 SHALL have parameter WAY_NUM_DIG, default 1: log2 of the number of ways, legal range 0..2.
REQ-004 SHALL have ports (name, direction, width, meaning):
  clk  in  1  sole clock; one clock domain, reset is synchronous and active-high.
  rst  in  1  synchronous active-high reset.
  ifu_araddr  in  32  fetch address; bits [1:0] are ignored.
  ifu_arvalid / ifu_arready  in / out  1  IFU read-address handshake.
  ifu_rdata  out  32  instruction word.
  ifu_rresp  out  2  response code: 2'b00 OKAY, otherwise the error code from refill.
  ifu_rvalid / ifu_rready  out / in  1  IFU read-data handshake.
  out_araddr  out  32  line-aligned refill address.
  out_arvalid / out_arready  out / in  1  refill address handshake.
  out_arlen  out  8  constant value 2^BLOCK_SIZE_WORD_DIG-1.
  out_arburst  out  2  constant value 2'b01 (INCR).
  out_rdata  in  32  refill beat data.
  out_rresp  in  2  refill beat response code.
  out_rvalid / out_rready  in / out  1  refill data handshake.
  out_rlast  in  1  marks the final refill beat.
  fence_i  in  1  invalidate-all request.

Function
REQ-005 SHALL split the address as: offset=[BSD-1:2], index=[BSD+SET_NUM_DIG-1:BSD], tag=[31:BSD+SET_NUM_DIG], where BSD=BLOCK_SIZE_WORD_DIG+2.
REQ-006 SHALL use the states IDLE, WAIT_IFU_READY, WAIT_OUT_READY and WAIT_OUT_REQ.
REQ-007 SHALL drive ifu_arready=1 only when in IDLE and fence_i=0 and flush_pending=0.
REQ-008 Hit behaviour: a hit is IDLE, ifu_arvalid=1 and a valid way whose tag matches.
  - SHALL assert ifu_rvalid in the same cycle, with the matching word and rresp=OKAY.
  - If ifu_rready=0, SHALL latch the word and go to WAIT_IFU_READY.
REQ-009 Miss behaviour: on a miss in IDLE, SHALL latch the address and select the victim way.
  - Victim is the lowest-numbered invalid way in the set; if none is invalid, the set's round-robin pointer.
  - SHALL then enter WAIT_OUT_READY.
REQ-010 SHALL assert out_arvalid only in WAIT_OUT_READY, with out_araddr={latched[31:BSD],0}; out_arready=1 moves the state to WAIT_OUT_REQ.
REQ-011 In WAIT_OUT_REQ:
  - SHALL assert out_rready.
  - Each accepted beat SHALL write victim word beat_cnt, then increment beat_cnt.
  - SHALL capture the beat whose beat_cnt equals offset for the IFU.
  - SHALL record the first non-OKAY out_rresp.
REQ-012 On a beat with out_rlast=1 (regardless of beat_cnt):
  - If no error was recorded: SHALL write the tag, set the victim valid, and advance that set's pointer modulo the number of ways.
  - If an error was recorded: SHALL clear the victim valid and leave the pointer unchanged.
  - Either way, SHALL go to WAIT_IFU_READY.
REQ-013 In WAIT_IFU_READY:
  - SHALL hold ifu_rvalid=1, with ifu_rdata and ifu_rresp (OKAY or the recorded error) stable.
  - ifu_rready=1 returns the state to IDLE.
REQ-014 fence_i handling:
  - In IDLE, fence_i=1 SHALL clear every valid bit in that cycle and accept no request.
  - In any other state, fence_i=1 SHALL set flush_pending.
  - On the first IDLE cycle with flush_pending set, SHALL clear all valid bits and flush_pending before accepting a request.
REQ-015 An in-flight refill SHALL complete and deliver its word even when a flush is pending; round-robin pointers SHALL NOT be reset by a flush.
REQ-016 With WAY_NUM_DIG=0, SHALL behave as a direct-mapped cache.

Reset
REQ-017 While rst=1, at the clock edge: state=IDLE, all valid bits=0, pointers=0, flush_pending=0, error flag=0.
REQ-018 Outputs after reset: ifu_rvalid=0, out_arvalid=0, out_rready=0, ifu_arready=1.
REQ-019 Data and tag arrays SHALL NOT be reset.
REQ-020 rst during a refill SHALL abandon the refill; no line is validated.

Structure
REQ-021 The shared package ysyx_25040129_cache_pkg SHALL hold the state encodings, the AXI resp constants (OKAY/SLVERR/DECERR) and the burst constants.
REQ-022 SHALL instantiate sub-module ysyx_25040129_icache_way (data, tag and valid storage for one way, with a tag compare output) 2^WAY_NUM_DIG times.

Verification (defaults: 16-byte lines, index [6:4], 2 ways)
REQ-023 Cold miss then hit:
  - Stimulus: read 0x8000_0008, supply beats D0..D3.
  - Required: out_araddr=0x8000_0000, out_arlen=3, ifu_rdata=D2.
  - Then read 0x8000_000C: rvalid in the same cycle with D3.
REQ-024 Set conflict:
  - Stimulus: fill 0x8000_0000 (way0), then 0x8000_0080 (way1), then 0x8000_0100.
  - Required: 0x8000_0100 evicts way0; 0x8000_0080 then hits and 0x8000_0000 then misses.
REQ-025 Flush during refill:
  - Stimulus: fence_i pulse during WAIT_OUT_REQ for 0x8000_0010.
  - Required: the word is still returned; ifu_arready=0 for one IDLE cycle; a repeat read of 0x8000_0010 misses.
REQ-026 Refill error:
  - Stimulus: out_rresp=2'b10 on beat 1.
  - Required: ifu_rresp=2'b10; a re-read of the same address misses and issues a new refill.
REQ-027 Backpressure and reset:
  - Stimulus: hold ifu_rready=0 for 3 cycles after a hit.
  - Required: rvalid and rdata stay stable.
  - Stimulus: assert rst mid-refill.
  - Required: state returns to IDLE and the next read misses.
